// File: rtl/sram_loader_pkg.sv
// Shared types, default geometry and the checksum term for the weight loader.
package sram_loader_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_DRAIN,
    ST_DONE
  } state_e;

  // Positional checksum term: the word XORed with its zero-extended index,
  // so swapped or misplaced words change the sum.
  function automatic logic [DATA_W-1:0] chk_term(input logic [DATA_W-1:0] word,
                                                 input logic [ADDR_W:0]   idx);
    return word ^ {{(DATA_W-ADDR_W-1){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/sram_rd_align.sv
// Two-stage valid/index delay line: pairs the macro read data with the
// index of the read command issued two edges earlier.
module sram_rd_align #(
  parameter int unsigned IDX_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_v_i,
  input  logic [IDX_W-1:0] issue_idx_i,
  output logic             ret_v_o,
  output logic [IDX_W-1:0] ret_idx_o
);

  logic             s1_v_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s2_v_q;
  logic [IDX_W-1:0] s2_idx_q;

  // Stage 1 tracks the command on the pins, stage 2 the cycle its data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      s2_idx_q <= '0;
    end else begin
      s1_v_q   <= issue_v_i;
      s1_idx_q <= issue_idx_i;
      s2_v_q   <= s1_v_q;
      s2_idx_q <= s1_idx_q;
    end
  end

  assign ret_v_o   = s2_v_q;
  assign ret_idx_o = s2_idx_q;

endmodule

// File: rtl/sram_weight_loader.sv
// Streams weight words into the 1024x32 SRAM macro from a programmable base,
// reads the region back and compares positional checksums before signalling done.
module sram_weight_loader #(
  parameter int unsigned ADDR_W = sram_loader_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_loader_pkg::DATA_W,
  parameter int unsigned DEPTH  = sram_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              sram_en,
  output logic              sram_r_wb,
  output logic [DATA_W-1:0] sram_ben,
  output logic [ADDR_W-1:0] sram_ad,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              cfg_err
);

  import sram_loader_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   idx_q;
  logic [DATA_W-1:0] wr_sum_q;
  logic [DATA_W-1:0] rd_sum_q;
  logic              drn_q;

  logic              s_ready_q;
  logic              en_q;
  logic              r_wb_q;
  logic [DATA_W-1:0] ben_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] di_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              cfg_err_q;

  logic [ADDR_W-1:0] addr_d;
  logic              last_d;
  logic              hs_d;
  logic              issue_v;
  logic              ret_v;
  logic [ADDR_W:0]   ret_idx;

  // Wrapping address and end-of-region detection for the current index.
  always_comb begin
    addr_d  = base_q + idx_q[ADDR_W-1:0];
    last_d  = (idx_q == (num_q - ONE_C));
    hs_d    = s_valid && s_ready_q;
    issue_v = (state_q == ST_RD_REQ);
  end

  sram_rd_align #(
    .IDX_W (ADDR_W + 1)
  ) u_rd_align (
    .clk         (clk),
    .rst         (rst),
    .issue_v_i   (issue_v),
    .issue_idx_i (idx_q),
    .ret_v_o     (ret_v),
    .ret_idx_o   (ret_idx)
  );

  // Load sequencer with registered macro pins and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      drn_q     <= 1'b0;
      s_ready_q <= 1'b0;
      en_q      <= 1'b0;
      r_wb_q    <= 1'b1;
      ben_q     <= '0;
      ad_q      <= '0;
      di_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ret_v) begin
        rd_sum_q <= rd_sum_q + chk_term(sram_do, ret_idx);
      end
      case (state_q)
        ST_IDLE: begin
          en_q   <= 1'b0;
          ben_q  <= '0;
          r_wb_q <= 1'b1;
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_words;
            idx_q     <= '0;
            pass_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            wr_sum_q  <= '0;
            rd_sum_q  <= '0;
            busy_q    <= 1'b1;
            if (num_words > DEPTH_C) begin
              cfg_err_q <= 1'b1;
              state_q   <= ST_DONE;
            end else if (num_words == '0) begin
              state_q <= ST_DONE;
            end else begin
              s_ready_q <= 1'b1;
              state_q   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (hs_d) begin
            en_q     <= 1'b1;
            r_wb_q   <= 1'b0;
            ben_q    <= '1;
            ad_q     <= addr_d;
            di_q     <= s_data;
            wr_sum_q <= wr_sum_q + chk_term(s_data, idx_q);
            if (last_d) begin
              s_ready_q <= 1'b0;
              idx_q     <= '0;
              state_q   <= ST_RD_REQ;
            end else begin
              idx_q <= idx_q + ONE_C;
            end
          end else begin
            en_q  <= 1'b0;
            ben_q <= '0;
          end
        end
        ST_RD_REQ: begin
          en_q   <= 1'b1;
          r_wb_q <= 1'b1;
          ben_q  <= '1;
          ad_q   <= addr_d;
          if (last_d) begin
            idx_q   <= '0;
            drn_q   <= 1'b0;
            state_q <= ST_RD_DRAIN;
          end else begin
            idx_q <= idx_q + ONE_C;
          end
        end
        ST_RD_DRAIN: begin
          // Two cycles let the last read's data land in rd_sum before DONE compares.
          en_q  <= 1'b0;
          ben_q <= '0;
          if (drn_q) begin
            drn_q   <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            drn_q <= 1'b1;
          end
        end
        ST_DONE: begin
          pass_q  <= !cfg_err_q && (rd_sum_q == wr_sum_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign sram_en   = en_q;
  assign sram_r_wb = r_wb_q;
  assign sram_ben  = ben_q;
  assign sram_ad   = ad_q;
  assign sram_di   = di_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cfg_err   = cfg_err_q;

endmodule
